// File: rtl/nn_argmax_stage.sv
`default_nettype none
// ==========================================================================
// nn_argmax_stage : streaming argmax (index + value) over M signed activations
// Optional macro ARGMAX_TIE_LAST_EN: ties resolve to the highest index.
// Revision: 1.0
// ==========================================================================
module nn_argmax_stage #(
  parameter int M    = 8,
  parameter int W    = 16,
  parameter int IDXW = $clog2(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    data_in,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [IDXW-1:0] max_idx,
  output logic [W-1:0]    max_val,
  output logic [15:0]     vec_done_count
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(M - 1);

  state_t          state;
  logic [IDXW-1:0] elem_cnt;
  logic [IDXW-1:0] best_idx;
  logic [W-1:0]    best_val;
  logic            beats;
  logic            take;

  // Element 0 always loads so a new vector never inherits the previous best.
  always_comb begin
    beats = 1'b0;
`ifdef ARGMAX_TIE_LAST_EN
    beats = ($signed(data_in) >= $signed(best_val));
`else
    beats = ($signed(data_in) > $signed(best_val));
`endif
    take = (elem_cnt == '0) || beats;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= COLLECT;
      s_ready        <= 1'b1;
      m_valid        <= 1'b0;
      max_idx        <= '0;
      max_val        <= '0;
      vec_done_count <= 16'd0;
      elem_cnt       <= '0;
      best_idx       <= '0;
      best_val       <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (s_valid && s_ready) begin
            if (take) begin
              best_val <= data_in;
              best_idx <= elem_cnt;
            end
            // The final element takes part in the comparison before publishing.
            if (elem_cnt == LAST_IDX) begin
              max_val  <= take ? data_in : best_val;
              max_idx  <= take ? elem_cnt : best_idx;
              m_valid  <= 1'b1;
              s_ready  <= 1'b0;
              elem_cnt <= '0;
              state    <= OUTPUT;
            end else begin
              elem_cnt <= elem_cnt + IDXW'(1);
            end
          end
        end
        OUTPUT: begin
          if (m_valid && m_ready) begin
            m_valid        <= 1'b0;
            s_ready        <= 1'b1;
            vec_done_count <= vec_done_count + 16'd1;
            state          <= COLLECT;
          end
        end
        default: begin
          state    <= COLLECT;
          s_ready  <= 1'b1;
          m_valid  <= 1'b0;
          elem_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nn_argmax_stage.sv
`default_nettype none
// Bench for nn_argmax_stage: directed vectors checked against a queued scoreboard.
module tb_nn_argmax_stage;

  localparam int M    = 8;
  localparam int W    = 16;
  localparam int IDXW = 3;
`ifdef ARGMAX_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  typedef logic signed [W-1:0] vec_t [M];
  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [W-1:0]    val;
  } res_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            s_valid;
  logic            s_ready;
  logic [W-1:0]    data_in;
  logic            m_valid;
  logic            m_ready;
  logic [IDXW-1:0] max_idx;
  logic [W-1:0]    max_val;
  logic [15:0]     vec_done_count;

  nn_argmax_stage #(.M(M), .W(W), .IDXW(IDXW)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .data_in        (data_in),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .max_idx        (max_idx),
    .max_val        (max_val),
    .vec_done_count (vec_done_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  res_t exp_q[$];
  int   checks      = 0;
  int   passes      = 0;
  int   exp_count   = 0;
  int   last_hs_cyc = 0;
  int   hs_gap      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic res_t model(input vec_t v);
    res_t r;
    r.idx = '0;
    r.val = v[0];
    for (int i = 1; i < M; i++) begin
      if ((v[i] > $signed(r.val)) || (TIE_LAST && (v[i] == $signed(r.val)))) begin
        r.val = v[i];
        r.idx = IDXW'(i);
      end
    end
    return r;
  endfunction

  // Result monitor: inputs change 1 time unit after posedge, so negedge is stable.
  always @(negedge clk) begin
    res_t e;
    if (!reset && m_valid && m_ready) begin
      chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("res_idx", 32'(max_idx), 32'(e.idx));
        chk("res_val", 32'(max_val), 32'(e.val));
      end
      exp_count   = exp_count + 1;
      hs_gap      = cyc - last_hs_cyc;
      last_hs_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves s_valid high so vectors can stream back to back.
  task automatic send(input logic [W-1:0] v);
    int n = 0;
    s_valid = 1'b1;
    data_in = v;
    while (!s_ready && n < 100) begin
      step();
      n++;
    end
    chk("send_ready_timeout", 32'(n < 100), 32'd1);
    step();
  endtask

  task automatic send_vec(input vec_t v, input int gap);
    exp_q.push_back(model(v));
    for (int i = 0; i < M; i++) begin
      if (i == M - 1) chk("no_early_valid", 32'(m_valid), 32'd0);
      send(v[i]);
      if (gap > 0 && i < M - 1) begin
        s_valid = 1'b0;
        repeat (gap) step();
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    res_t e;
    int   n;

    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    data_in = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_max_idx", 32'(max_idx), 32'd0);
    chk("rst_max_val", 32'(max_val), 32'd0);
    chk("rst_count",   32'(vec_done_count), 32'd0);

    // Tie-break
    m_ready = 1'b1;
    v = '{16'sd3, -16'sd5, 16'sd9, 16'sd2, 16'sd9, 16'sd0, -16'sd1, 16'sd7};
    send_vec(v, 0);
    s_valid = 1'b0;
    chk("tie_valid", 32'(m_valid), 32'd1);
    chk("tie_idx",   32'(max_idx), TIE_LAST ? 32'd4 : 32'd2);
    chk("tie_val",   32'(max_val), 32'd9);
    step();
    chk("tie_pulse", 32'(m_valid), 32'd0);
    chk("tie_count", 32'(vec_done_count), 32'd1);

    // All-negative, minimum value never wins
    v = '{-16'sd10, -16'sd3, -16'sd8, 16'sh8000, -16'sd4, -16'sd3, -16'sd100, -16'sd7};
    send_vec(v, 0);
    s_valid = 1'b0;
    chk("neg_idx", 32'(max_idx), TIE_LAST ? 32'd5 : 32'd1);
    chk("neg_val", 32'(max_val), 32'h0000_FFFD);
    step();

    // Backpressure: result held while data 50 is offered and must be ignored
    m_ready = 1'b0;
    v = '{16'sd4, -16'sd2, 16'sd11, 16'sd0, 16'sd6, 16'sd11, 16'sd3, 16'sd1};
    e = model(v);
    send_vec(v, 0);
    data_in = 16'd50;
    repeat (5) begin
      step();
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      chk("bp_idx",     32'(max_idx), 32'(e.idx));
      chk("bp_val",     32'(max_val), 32'(e.val));
      chk("bp_count",   32'(vec_done_count), 32'(exp_count));
    end
    m_ready = 1'b1;
    s_valid = 1'b0;
    step();
    chk("bp_release_ready", 32'(s_ready), 32'd1);
    chk("bp_release_valid", 32'(m_valid), 32'd0);
    chk("bp_release_count", 32'(vec_done_count), 32'd3);
    v = '{-16'sd1, -16'sd2, -16'sd3, -16'sd4, -16'sd5, -16'sd6, -16'sd7, -16'sd8};
    send_vec(v, 0);
    s_valid = 1'b0;
    step();

    // Bubbles between every element
    v = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd127};
    send_vec(v, 2);
    s_valid = 1'b0;
    chk("bub_valid", 32'(m_valid), 32'd1);
    chk("bub_idx",   32'(max_idx), 32'd7);
    chk("bub_val",   32'(max_val), 32'd127);
    step();
    chk("bub_pulse", 32'(m_valid), 32'd0);

    // Reset mid-vector discards the partial vector
    repeat (3) send(16'd100);
    s_valid = 1'b0;
    reset   = 1'b1;
    step();
    reset     = 1'b0;
    exp_count = 0;
    chk("mid_rst_count", 32'(vec_done_count), 32'd0);
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    v = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd5, 16'sd0};
    send_vec(v, 0);
    s_valid = 1'b0;
    chk("mid_rst_idx", 32'(max_idx), 32'd6);
    chk("mid_rst_val", 32'(max_val), 32'd5);
    step();
    chk("mid_rst_count_after", 32'(vec_done_count), 32'd1);

    // Back-to-back streaming
    v = '{16'sd9, 16'sd8, 16'sd7, 16'sd6, 16'sd5, 16'sd4, 16'sd3, 16'sd2};
    send_vec(v, 0);
    v = '{-16'sd100, -16'sd100, -16'sd100, -16'sd100, -16'sd100, -16'sd100, -16'sd100, -16'sd100};
    send_vec(v, 0);
    s_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    step();
    chk("b2b_drain",  32'(exp_q.size()), 32'd0);
    chk("b2b_period", 32'(hs_gap), 32'd9);
    chk("final_count", 32'(vec_done_count), 32'(exp_count));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
